// File: rtl/decode.sv
// Decode stage: 32x32 register file, immediate extension, ALU/memory/branch/jump control.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds a sticky illegal-instruction flag and squashes controls.
module decode #(
  parameter int INIT_FROM_INDEX = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] pc4,
  input  logic [31:0] wb_data,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  output logic [31:0] imm_ext,
  output logic [2:0]  alu_ctrl,
  output logic        alu_src,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        do_branch,
  output logic        do_jump,
  output logic [31:0] branch_addr,
  output logic [27:0] jump_shifted_address,
  output logic        illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];

  logic is_nop, is_rtype, is_add, is_sub, is_and, is_or, is_slt, is_alu_r;
  logic is_lw, is_sw, is_beq, is_lui, is_ori, is_j, is_jal;

  always_comb begin
    is_nop   = (instruction == 32'h0);
    is_rtype = (opcode == OP_RTYPE) && !is_nop;
    is_add   = is_rtype && (funct == F_ADD);
    is_sub   = is_rtype && (funct == F_SUB);
    is_and   = is_rtype && (funct == F_AND);
    is_or    = is_rtype && (funct == F_OR);
    is_slt   = is_rtype && (funct == F_SLT);
    is_alu_r = is_add | is_sub | is_and | is_or | is_slt;
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_lui   = (opcode == OP_LUI);
    is_ori   = (opcode == OP_ORI);
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
  end

  // trap is high only for unsupported encodings when the trap feature is built in
  logic trap;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic legal;
  logic illegal_q;
  logic illegal_d;

  assign legal = is_nop | is_alu_r | is_lw | is_sw | is_beq | is_lui | is_ori | is_j | is_jal;
  assign trap  = !legal;

  always_comb begin
    illegal_d = illegal_q | trap;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign trap       = 1'b0;
  assign illegal_op = 1'b0;
`endif

  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always_comb begin
    reg_write  = (is_alu_r | is_lw | is_lui | is_ori | is_jal) & !trap;
    wr_addr    = is_alu_r ? rd : (is_jal ? 5'd31 : rt);
    wr_data    = is_jal ? pc4 : wb_data;
    alu_src    = is_lw | is_sw | is_ori | is_lui;
    mem_write  = is_sw & !trap;
    mem_to_reg = is_lw & !trap;
    do_jump    = (is_j | is_jal) & !trap;
    imm_ext    = (is_ori | is_lui) ? {16'h0, instruction[15:0]}
                                   : {{16{instruction[15]}}, instruction[15:0]};
    alu_ctrl   = ALU_ADD;
    if (is_sub | is_beq) alu_ctrl = ALU_SUB;
    if (is_and)          alu_ctrl = ALU_AND;
    if (is_or | is_ori)  alu_ctrl = ALU_OR;
    if (is_slt)          alu_ctrl = ALU_SLT;
    if (is_lui)          alu_ctrl = ALU_LUI;
  end

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (reg_write && (wr_addr != 5'd0)) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= (INIT_FROM_INDEX != 0) ? 32'(i) : 32'h0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the pre-edge contents; there is no write-to-read bypass
  assign read_data_1 = (rs == 5'd0) ? 32'h0 : regs_q[rs];
  assign read_data_2 = (rt == 5'd0) ? 32'h0 : regs_q[rt];

  assign do_branch            = is_beq & (read_data_1 == read_data_2) & !trap;
  assign branch_addr          = pc4 + {imm_ext[29:0], 2'b00};
  assign jump_shifted_address = {instruction[25:0], 2'b00};

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: scoreboard queue of expected values, immediate-assertion checks.
module tb_decode;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] pc4;
  logic [31:0] wb_data;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] imm_ext;
  logic [2:0]  alu_ctrl;
  logic        alu_src;
  logic        mem_write;
  logic        mem_to_reg;
  logic        do_branch;
  logic        do_jump;
  logic [31:0] branch_addr;
  logic [27:0] jump_shifted_address;
  logic        illegal_op;

  decode #(.INIT_FROM_INDEX(1)) dut (
    .clock                (clock),
    .reset                (reset),
    .instruction          (instruction),
    .pc4                  (pc4),
    .wb_data              (wb_data),
    .read_data_1          (read_data_1),
    .read_data_2          (read_data_2),
    .imm_ext              (imm_ext),
    .alu_ctrl             (alu_ctrl),
    .alu_src              (alu_src),
    .mem_write            (mem_write),
    .mem_to_reg           (mem_to_reg),
    .do_branch            (do_branch),
    .do_jump              (do_jump),
    .branch_addr          (branch_addr),
    .jump_shifted_address (jump_shifted_address),
    .illegal_op           (illegal_op)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // driver tasks
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] wb);
    @(negedge clock);
    instruction = ins;
    pc4         = pc;
    wb_data     = wb;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard
  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // beq rX,$0 with zero offset: reads a register without writing anything
  task automatic read_reg(input logic [4:0] r, input logic [31:0] e, input string tag);
    drive({6'h04, r, 5'd0, 16'h0}, 32'h0, 32'h0);
    push_exp(e);
    check(tag, read_data_1);
  endtask

  logic [5:0] fn_t [5];
  logic [2:0] ac_t [5];

  initial begin
    fn_t = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    ac_t = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    reset       = 1'b0;
    instruction = 32'h0;
    pc4         = 32'h0;
    wb_data     = 32'h0;

    // held in reset: reads show reset contents, no writes happen
    drive(32'h00832820, 32'h0, 32'd6);
    push_exp(32'd0); check("rst_illegal", 32'(illegal_op));
    push_exp(32'd4); check("rst_rd1", read_data_1);
    push_exp(32'd3); check("rst_rd2", read_data_2);
    tick();
    tick();
    read_reg(5'd5, 32'd5, "rst_no_write_r5");

    // release reset, add $5,$4,$3 with wb_data 6
    drive(32'h00832820, 32'h0, 32'd6);
    reset = 1'b1;
    #1;
    push_exp(32'd4); check("add_rd1", read_data_1);
    push_exp(32'd3); check("add_rd2", read_data_2);
    push_exp(32'd2); check("add_alu", 32'(alu_ctrl));
    push_exp(32'd0); check("add_alu_src", 32'(alu_src));
    tick();
    read_reg(5'd5, 32'd6, "add_r5");

    // $5 = 1, then beq $5,$1 taken
    drive(32'h00002820, 32'h0, 32'd1);
    tick();
    drive(32'h10a10003, 32'h2c, 32'h0);
    push_exp(32'd1);  check("beq_taken", 32'(do_branch));
    push_exp(32'h38); check("beq_addr", branch_addr);
    push_exp(32'd3);  check("beq_imm", imm_ext);
    push_exp(32'd6);  check("beq_alu", 32'(alu_ctrl));
    push_exp(32'd0);  check("beq_jump", 32'(do_jump));

    // $5 = 2, beq not taken
    drive(32'h00002820, 32'h0, 32'd2);
    tick();
    drive(32'h10a10003, 32'h2c, 32'h0);
    push_exp(32'd0);  check("beq_not_taken", 32'(do_branch));
    push_exp(32'h38); check("beq_addr2", branch_addr);

    // negative offset wraps modulo 2^32
    drive({6'h04, 5'd0, 5'd0, 16'hffff}, 32'h0, 32'h0);
    push_exp(32'hffffffff); check("beq_neg_imm", imm_ext);
    push_exp(32'hfffffffc); check("beq_wrap_addr", branch_addr);
    push_exp(32'd1);        check("beq_zero_taken", 32'(do_branch));

    // jal
    drive(32'h0c000011, 32'h3c, 32'hdeadbeef);
    push_exp(32'd1);    check("jal_jump", 32'(do_jump));
    push_exp(32'h44);   check("jal_target", 32'(jump_shifted_address));
    push_exp(32'd0);    check("jal_no_branch", 32'(do_branch));
    tick();
    read_reg(5'd31, 32'h3c, "jal_r31");

    // lui then ori on $6
    drive(32'h3c06abcd, 32'h0, 32'h1234);
    push_exp(32'h0000abcd); check("lui_imm", imm_ext);
    push_exp(32'd3);        check("lui_alu", 32'(alu_ctrl));
    push_exp(32'd1);        check("lui_alu_src", 32'(alu_src));
    tick();
    drive(32'h34c6e039, 32'h0, 32'h5678);
    push_exp(32'h0000e039); check("ori_imm", imm_ext);
    push_exp(32'd1);        check("ori_alu", 32'(alu_ctrl));
    push_exp(32'h1234);     check("ori_rd1_r6", read_data_1);
    tick();
    read_reg(5'd6, 32'h5678, "ori_r6");

    // attempted write to $0
    drive(32'h00200020, 32'h0, 32'hffffffff);
    tick();
    read_reg(5'd0, 32'h0, "r0_stays_zero");

    // same-cycle read returns old value, new value after the edge
    drive({6'h0, 5'd7, 5'd0, 5'd7, 5'd0, 6'h20}, 32'h0, 32'h99);
    push_exp(32'd7);  check("old_value_r7", read_data_1);
    tick();
    push_exp(32'h99); check("new_value_r7", read_data_1);

    // lw and sw
    drive({6'h23, 5'd0, 5'd8, 16'h8000}, 32'h0, 32'h55);
    push_exp(32'hffff8000); check("lw_imm", imm_ext);
    push_exp(32'd1);        check("lw_mem_to_reg", 32'(mem_to_reg));
    push_exp(32'd0);        check("lw_mem_write", 32'(mem_write));
    push_exp(32'd2);        check("lw_alu", 32'(alu_ctrl));
    tick();
    read_reg(5'd8, 32'h55, "lw_r8");
    drive({6'h2b, 5'd0, 5'd9, 16'h0004}, 32'h0, 32'h77);
    push_exp(32'd1); check("sw_mem_write", 32'(mem_write));
    push_exp(32'd0); check("sw_mem_to_reg", 32'(mem_to_reg));
    push_exp(32'd1); check("sw_alu_src", 32'(alu_src));
    tick();
    read_reg(5'd9, 32'd9, "sw_no_write_r9");

    // R-type ALU control table
    for (int i = 0; i < 5; i++) begin
      drive({6'h0, 5'd1, 5'd2, 5'd0, 5'd0, fn_t[i]}, 32'h0, 32'h0);
      push_exp(32'(ac_t[i]));
      check("rtype_alu", 32'(alu_ctrl));
    end

    // unsupported opcode 0x3f targeting $10
    drive({6'h3f, 5'd0, 5'd10, 16'h0}, 32'h0, 32'haa);
    push_exp(32'd0); check("ill_mem_write", 32'(mem_write));
    push_exp(32'd0); check("ill_jump", 32'(do_jump));
    push_exp(32'd0); check("ill_branch", 32'(do_branch));
    push_exp(32'd0); check("ill_before_edge", 32'(illegal_op));
    tick();
    push_exp(32'(TRAP)); check("ill_set", 32'(illegal_op));
    read_reg(5'd10, 32'd10, "ill_no_write_r10");
    tick();
    push_exp(32'(TRAP)); check("ill_held", 32'(illegal_op));

    // unsupported funct targeting $11
    drive({6'h0, 5'd1, 5'd2, 5'd11, 5'd0, 6'h3f}, 32'h0, 32'hbb);
    tick();
    read_reg(5'd11, 32'd11, "ill_funct_no_write_r11");

    // asynchronous reset clears flag and restores registers without an edge
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    push_exp(32'd0); check("async_clear_illegal", 32'(illegal_op));
    instruction = {6'h04, 5'd5, 5'd0, 16'h0};
    #1;
    push_exp(32'd5); check("async_reset_r5", read_data_1);
    drive({6'h0, 5'd0, 5'd0, 5'd12, 5'd0, 6'h20}, 32'h0, 32'hcc);
    tick();
    read_reg(5'd12, 32'd12, "reset_blocks_write_r12");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
